// File: rtl/jpeb_isa_pkg.sv
// Shared ISA definitions for the RiSC-16-style instruction set:
// opcode values, field positions, the bubble instruction word,
// the decoded-bundle type and the 7-bit immediate sign extender.
package jpeb_isa_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 13;
  localparam int RA_HI   = 12;
  localparam int RA_LO   = 10;
  localparam int RB_HI   = 9;
  localparam int RB_LO   = 7;
  localparam int RC_HI   = 2;
  localparam int RC_LO   = 0;
  localparam int IMM7_HI = 6;
  localparam int LUI_HI  = 9;

  // add r0,r0,r0 : architecturally a no-op
  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rc;
    logic [15:0] imm;
    logic        is_branch;
    logic        is_jalr;
    logic        is_load;
    logic        is_store;
    logic        writes_reg;
  } dec_t;

  function automatic logic [15:0] sext7(input logic [6:0] v);
    return {{9{v[6]}}, v};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder: splits a 16-bit word into
// fields, immediate and control flags, and reports which registers it reads.
module instr_decoder
  import jpeb_isa_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        dec,
  output logic [2:0]  src0,
  output logic [2:0]  src1,
  output logic [1:0]  src_used
);

  // Field extraction, immediate formation, flags and source selection
  always_comb begin
    dec          = '0;
    src0         = '0;
    src1         = '0;
    src_used     = '0;
    dec.opcode   = instr[OPC_HI:OPC_LO];
    dec.ra       = instr[RA_HI:RA_LO];
    dec.rb       = instr[RB_HI:RB_LO];
    dec.rc       = instr[RC_HI:RC_LO];
    case (dec.opcode)
      OP_ADD, OP_NAND: begin
        src0     = dec.rb;
        src1     = dec.rc;
        src_used = 2'b11;
      end
      OP_ADDI: begin
        dec.imm  = sext7(instr[IMM7_HI:0]);
        src0     = dec.rb;
        src_used = 2'b01;
      end
      OP_LUI: begin
        dec.imm  = {instr[LUI_HI:0], 6'b0};
      end
      OP_SW: begin
        dec.imm      = sext7(instr[IMM7_HI:0]);
        dec.is_store = 1'b1;
        src0         = dec.ra;
        src1         = dec.rb;
        src_used     = 2'b11;
      end
      OP_LW: begin
        dec.imm     = sext7(instr[IMM7_HI:0]);
        dec.is_load = 1'b1;
        src0        = dec.rb;
        src_used    = 2'b01;
      end
      OP_BEQ: begin
        dec.imm       = sext7(instr[IMM7_HI:0]);
        dec.is_branch = 1'b1;
        src0          = dec.ra;
        src1          = dec.rb;
        src_used      = 2'b11;
      end
      default: begin // OP_JALR
        dec.is_jalr = 1'b1;
        src0        = dec.rb;
        src_used    = 2'b01;
      end
    endcase
    // r0 is hardwired, so writes to it are not real writes
    dec.writes_reg = (dec.opcode != OP_SW) && (dec.opcode != OP_BEQ) && (dec.ra != 3'd0);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: selects the instruction (skid or memory), decodes
// it, drives register-file read addresses, detects load-use hazards and
// registers the decoded bundle for execute.
module decode_stage
  import jpeb_isa_pkg::*;
#(
  parameter int          PC_W      = 16,
  parameter logic [15:0] NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            bubble_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic [15:0]     mem_data,
  output logic [2:0]      rf_raddr0,
  output logic [2:0]      rf_raddr1,
  output logic            hazard_stall,
  output logic            bubble_out,
  output logic [PC_W-1:0] pc_out,
  output logic [2:0]      opcode,
  output logic [2:0]      ra,
  output logic [2:0]      rb,
  output logic [2:0]      rc,
  output logic [15:0]     imm,
  output logic            is_branch,
  output logic            is_jalr,
  output logic            is_load,
  output logic            is_store,
  output logic            writes_reg
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  logic [0:0]      state_reg;
  logic            skid_valid_reg;
  logic [15:0]     skid_instr_reg;
  logic [PC_W-1:0] skid_pc_reg;

  logic            bubble_out_reg;
  logic [PC_W-1:0] pc_out_reg;
  dec_t            dec_reg;

  logic [15:0]     instr_sel;
  logic [PC_W-1:0] pc_sel;
  logic            bubble_sel;
  logic [15:0]     instr_dec;
  dec_t            dec_sel;
  logic [2:0]      src0;
  logic [2:0]      src1;
  logic [1:0]      src_used;
  logic            src0_hit;
  logic            src1_hit;
  logic            capture;

  // A held instruction is always a real one, so a loaded skid never bubbles
  assign instr_sel  = skid_valid_reg ? skid_instr_reg : mem_data;
  assign pc_sel     = skid_valid_reg ? skid_pc_reg : pc_in;
  assign bubble_sel = skid_valid_reg ? 1'b0 : bubble_in;
  assign instr_dec  = bubble_sel ? NOP_INSTR : instr_sel;

  instr_decoder u_dec (
    .instr    (instr_dec),
    .dec      (dec_sel),
    .src0     (src0),
    .src1     (src1),
    .src_used (src_used)
  );

  assign rf_raddr0 = src0;
  assign rf_raddr1 = src1;

  // Load-use: the load now in the output register targets a source we read
  assign src0_hit = src_used[0] && (src0 == dec_reg.ra) && (src0 != 3'd0);
  assign src1_hit = src_used[1] && (src1 == dec_reg.ra) && (src1 != 3'd0);
  assign hazard_stall = !bubble_out_reg && dec_reg.is_load && dec_reg.writes_reg &&
                        !bubble_sel && (src0_hit || src1_hit);

  // Park a real memory instruction when it cannot issue this cycle
  assign capture = (stall || hazard_stall) && (state_reg == ST_RUN) && !bubble_in;

  // Pipeline register, skid register and RUN/HELD control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_RUN;
      skid_valid_reg <= 1'b0;
      skid_instr_reg <= '0;
      skid_pc_reg    <= '0;
      bubble_out_reg <= 1'b1;
      pc_out_reg     <= '0;
      dec_reg        <= '0;
    end else if (flush) begin
      state_reg      <= ST_RUN;
      skid_valid_reg <= 1'b0;
      bubble_out_reg <= 1'b1;
      dec_reg        <= '0;
    end else if (stall || hazard_stall) begin
      if (capture) begin
        state_reg      <= ST_HELD;
        skid_valid_reg <= 1'b1;
        skid_instr_reg <= mem_data;
        skid_pc_reg    <= pc_in;
      end
      // a hazard inserts a bubble; a downstream stall freezes everything
      if (!stall) begin
        bubble_out_reg <= 1'b1;
        dec_reg        <= '0;
      end
    end else begin
      bubble_out_reg <= bubble_sel;
      pc_out_reg     <= pc_sel;
      dec_reg        <= dec_sel;
      if (state_reg == ST_HELD) begin
        state_reg      <= ST_RUN;
        skid_valid_reg <= 1'b0;
      end
    end
  end

  assign bubble_out = bubble_out_reg;
  assign pc_out     = pc_out_reg;
  assign opcode     = dec_reg.opcode;
  assign ra         = dec_reg.ra;
  assign rb         = dec_reg.rb;
  assign rc         = dec_reg.rc;
  assign imm        = dec_reg.imm;
  assign is_branch  = dec_reg.is_branch;
  assign is_jalr    = dec_reg.is_jalr;
  assign is_load    = dec_reg.is_load;
  assign is_store   = dec_reg.is_store;
  assign writes_reg = dec_reg.writes_reg;

endmodule
